// File: rtl/vram_port_arbiter.sv
// Shares one synchronous-read VRAM port between the Avalon CPU slave and the
// text renderer prefetch; renderer has priority, CPU is force-granted when starved.
module vram_port_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int NUM_WORDS  = 601,
   parameter int STARVE_MAX = 8
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              AVL_CS,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic [3:0]        AVL_BYTE_EN,
   input  logic [ADDR_W-1:0] AVL_ADDR,
   input  logic [DATA_W-1:0] AVL_WRITEDATA,
   output logic [DATA_W-1:0] AVL_READDATA,
   output logic              AVL_WAITREQUEST,
   input  logic              REN_REQ,
   input  logic [ADDR_W-1:0] REN_ADDR,
   output logic              REN_ACK,
   output logic [DATA_W-1:0] REN_DATA,
   output logic              REN_VALID,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [3:0]        RAM_BE,
   output logic [DATA_W-1:0] RAM_WDATA,
   output logic              RAM_WE,
   input  logic [DATA_W-1:0] RAM_Q
);

   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] ADDR_LIM   = ADDR_W'(NUM_WORDS);

   logic              rd_pend_q, rd_pend_d;
   logic              rd_unmapped_q, rd_unmapped_d;
   logic              ren_valid_q, ren_valid_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              cpu_req, cpu_grant, ren_grant, cpu_mapped;

   // Grants are suppressed while reset is low so the RAM never sees a write then.
   always_comb begin
      cpu_req    = RESET_N & AVL_CS & (AVL_READ | AVL_WRITE) & ~rd_pend_q;
      cpu_grant  = cpu_req & (~REN_REQ | (starve_q == STARVE_LIM));
      ren_grant  = RESET_N & REN_REQ & ~cpu_grant;
      cpu_mapped = AVL_ADDR < ADDR_LIM;
   end

   always_comb begin
      RAM_ADDR  = '0;
      RAM_BE    = '0;
      RAM_WDATA = '0;
      RAM_WE    = 1'b0;
      if (cpu_grant) begin
         RAM_ADDR = AVL_ADDR;
         if (AVL_WRITE) begin
            RAM_WE    = cpu_mapped;
            RAM_BE    = AVL_BYTE_EN;
            RAM_WDATA = AVL_WRITEDATA;
         end
      end else if (ren_grant) begin
         RAM_ADDR = REN_ADDR;
      end
   end

   always_comb begin
      rd_pend_d     = cpu_grant & ~AVL_WRITE;
      rd_unmapped_d = cpu_grant & ~AVL_WRITE & ~cpu_mapped;
      ren_valid_d   = ren_grant;
      starve_d      = '0;
      if (cpu_req && !cpu_grant) begin
         starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + CNT_W'(1);
      end
      rdata_d = rdata_q;
      if (rd_pend_q) begin
         rdata_d = rd_unmapped_q ? '0 : RAM_Q;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_pend_q     <= 1'b0;
         rd_unmapped_q <= 1'b0;
         ren_valid_q   <= 1'b0;
         starve_q      <= '0;
         rdata_q       <= '0;
      end else begin
         rd_pend_q     <= rd_pend_d;
         rd_unmapped_q <= rd_unmapped_d;
         ren_valid_q   <= ren_valid_d;
         starve_q      <= starve_d;
         rdata_q       <= rdata_d;
      end
   end

   // A read completes in the cycle after its grant, when rd_pend_q masks cpu_req.
   always_comb begin
      AVL_READDATA    = rdata_d;
      AVL_WAITREQUEST = ~RESET_N | (cpu_req & ~(cpu_grant & AVL_WRITE));
      REN_ACK         = ren_grant;
      REN_VALID       = ren_valid_q;
      REN_DATA        = RAM_Q;
   end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed scenarios plus a random
// mix of CPU and renderer traffic checked against a shadow memory model.
module tb_vram_port_arbiter;

   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 32;
   localparam int NUM_WORDS  = 601;
   localparam int STARVE_MAX = 8;

   logic              CLK = 1'b0;
   logic              RESET_N = 1'b1;
   logic              AVL_CS, AVL_READ, AVL_WRITE;
   logic [3:0]        AVL_BYTE_EN;
   logic [ADDR_W-1:0] AVL_ADDR;
   logic [DATA_W-1:0] AVL_WRITEDATA;
   logic [DATA_W-1:0] AVL_READDATA;
   logic              AVL_WAITREQUEST;
   logic              REN_REQ;
   logic [ADDR_W-1:0] REN_ADDR;
   logic              REN_ACK;
   logic [DATA_W-1:0] REN_DATA;
   logic              REN_VALID;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic [3:0]        RAM_BE;
   logic [DATA_W-1:0] RAM_WDATA;
   logic              RAM_WE;
   logic [DATA_W-1:0] RAM_Q;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] vram    [0:NUM_WORDS-1];
   logic [DATA_W-1:0] ref_mem [0:NUM_WORDS-1];

   always #5 CLK = ~CLK;

   vram_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
      .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
      .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
      .REN_REQ(REN_REQ), .REN_ADDR(REN_ADDR), .REN_ACK(REN_ACK),
      .REN_DATA(REN_DATA), .REN_VALID(REN_VALID),
      .RAM_ADDR(RAM_ADDR), .RAM_BE(RAM_BE), .RAM_WDATA(RAM_WDATA),
      .RAM_WE(RAM_WE), .RAM_Q(RAM_Q)
   );

   function automatic logic [31:0] init_word(input int i);
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Single-port VRAM with registered read; unmapped reads return a poison word.
   initial for (int i = 0; i < NUM_WORDS; i++) vram[i] = init_word(i);
   always @(posedge CLK) begin
      if (RAM_WE && RAM_ADDR < NUM_WORDS)
         for (int b = 0; b < 4; b++)
            if (RAM_BE[b]) vram[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
      RAM_Q <= (RAM_ADDR < NUM_WORDS) ? vram[RAM_ADDR] : 32'hBADB_AD00;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic idle_inputs();
      AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_BYTE_EN = 0;
      AVL_ADDR = 0; AVL_WRITEDATA = 0; REN_REQ = 0; REN_ADDR = 0;
   endtask

   // Drivers start and end positioned on a falling clock edge.
   task automatic cpu_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] be,
                            output int waits, output logic we, output logic [11:0] ram_addr,
                            output logic [3:0] ram_be, output logic [31:0] ram_wdata,
                            output logic timeout);
      AVL_CS = 1; AVL_WRITE = 1; AVL_READ = 0; AVL_ADDR = addr;
      AVL_WRITEDATA = data; AVL_BYTE_EN = be;
      waits = 0; timeout = 0;
      #1;
      while (AVL_WAITREQUEST === 1'b1) begin
         waits++;
         if (waits > 20) begin timeout = 1; break; end
         @(negedge CLK); #1;
      end
      we = RAM_WE; ram_addr = RAM_ADDR; ram_be = RAM_BE; ram_wdata = RAM_WDATA;
      @(negedge CLK);
      AVL_CS = 0; AVL_WRITE = 0;
      if (!timeout && addr < NUM_WORDS) ref_mem[addr] = merge_bytes(ref_mem[addr], data, be);
   endtask

   task automatic cpu_read(input logic [11:0] addr, output int waits, output logic [31:0] data,
                           output logic timeout);
      AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 0; AVL_ADDR = addr; AVL_BYTE_EN = 4'hF;
      waits = 0; timeout = 0;
      #1;
      while (AVL_WAITREQUEST === 1'b1) begin
         waits++;
         if (waits > 20) begin timeout = 1; break; end
         @(negedge CLK); #1;
      end
      data = AVL_READDATA;
      AVL_CS = 0; AVL_READ = 0;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 RESET_N = 0;
      @(negedge CLK);
      AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 12'd3; AVL_BYTE_EN = 4'hF; REN_REQ = 1;
      #1;
      checks++; if (AVL_WAITREQUEST !== 1'b1) begin errors++; $display("[TB] FAIL reset_waitreq: got %b expected 1", AVL_WAITREQUEST); end
      checks++; if (REN_ACK !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren_ack: got %b expected 0", REN_ACK); end
      checks++; if (RAM_WE !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we: got %b expected 0", RAM_WE); end
      checks++; if (REN_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren_valid: got %b expected 0", REN_VALID); end
      checks++; if (AVL_READDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_readdata: got %h expected 0", AVL_READDATA); end
      @(negedge CLK);
      idle_inputs();
      RESET_N = 1;
      #1;
      checks++; if (AVL_WAITREQUEST !== 1'b0) begin errors++; $display("[TB] FAIL idle_waitreq: got %b expected 0", AVL_WAITREQUEST); end
      @(negedge CLK);
   endtask

   task automatic test_write_basic();
      int waits; logic we, to; logic [11:0] ra; logic [3:0] rb; logic [31:0] rw, rd;
      cpu_write(12'd5, 32'hDEADBEEF, 4'hF, waits, we, ra, rb, rw, to);
      checks++; if (to || waits != 0) begin errors++; $display("[TB] FAIL write_latency: got %0d wait cycles expected 0", waits); end
      checks++; if (we !== 1'b1 || ra !== 12'd5) begin errors++; $display("[TB] FAIL write_port: got we=%b addr=%0d expected we=1 addr=5", we, ra); end
      checks++; if (rb !== 4'hF || rw !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_data: got be=%h data=%h expected f deadbeef", rb, rw); end
      cpu_read(12'd5, waits, rd, to);
      checks++; if (to || waits != 1) begin errors++; $display("[TB] FAIL read_latency: got %0d wait cycles expected 1", waits); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", rd); end
   endtask

   task automatic test_byte_enable();
      int waits; logic we, to; logic [11:0] ra; logic [3:0] rb; logic [31:0] rw, rd;
      cpu_write(12'd9, 32'h11223344, 4'hF, waits, we, ra, rb, rw, to);
      cpu_write(12'd9, 32'h00AB0000, 4'b0100, waits, we, ra, rb, rw, to);
      checks++; if (rb !== 4'b0100) begin errors++; $display("[TB] FAIL be_port: got %b expected 0100", rb); end
      cpu_read(12'd9, waits, rd, to);
      checks++; if (rd !== 32'h11AB3344) begin errors++; $display("[TB] FAIL be_merge: got %h expected 11ab3344", rd); end
      cpu_write(12'd9, 32'hFFFFFFFF, 4'b0000, waits, we, ra, rb, rw, to);
      checks++; if (to || waits != 0) begin errors++; $display("[TB] FAIL be_zero_ack: got %0d wait cycles expected 0", waits); end
      cpu_read(12'd9, waits, rd, to);
      checks++; if (rd !== 32'h11AB3344) begin errors++; $display("[TB] FAIL be_zero_keep: got %h expected 11ab3344", rd); end
   endtask

   task automatic test_unmapped();
      int waits; logic we, to; logic [11:0] ra; logic [3:0] rb; logic [31:0] rw, rd;
      cpu_read(12'd700, waits, rd, to);
      checks++; if (to || waits != 1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got waits=%0d data=%h expected 1 00000000", waits, rd); end
      cpu_write(12'd700, 32'h12345678, 4'hF, waits, we, ra, rb, rw, to);
      checks++; if (to || waits != 0 || we !== 1'b0) begin errors++; $display("[TB] FAIL unmapped_write: got waits=%0d we=%b expected 0 0", waits, we); end
      cpu_write(12'd600, 32'hCAFE0600, 4'hF, waits, we, ra, rb, rw, to);
      checks++; if (we !== 1'b1) begin errors++; $display("[TB] FAIL last_word_we: got %b expected 1", we); end
      cpu_read(12'd600, waits, rd, to);
      checks++; if (rd !== 32'hCAFE0600) begin errors++; $display("[TB] FAIL last_word_read: got %h expected cafe0600", rd); end
      cpu_read(12'd601, waits, rd, to);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL first_unmapped_read: got %h expected 0", rd); end
   endtask

   task automatic test_ren_stream();
      for (int k = 0; k < 3; k++) begin
         REN_REQ = 1; REN_ADDR = 12'(k);
         #1;
         checks++; if (REN_ACK !== 1'b1 || RAM_ADDR !== 12'(k)) begin errors++; $display("[TB] FAIL stream_ack%0d: got ack=%b addr=%0d expected 1 %0d", k, REN_ACK, RAM_ADDR, k); end
         if (k == 0) begin
            checks++; if (REN_VALID !== 1'b0) begin errors++; $display("[TB] FAIL stream_valid_first: got %b expected 0", REN_VALID); end
         end else begin
            checks++; if (REN_VALID !== 1'b1 || REN_DATA !== ref_mem[k-1]) begin errors++; $display("[TB] FAIL stream_data%0d: got v=%b %h expected 1 %h", k-1, REN_VALID, REN_DATA, ref_mem[k-1]); end
         end
         @(negedge CLK);
      end
      REN_REQ = 0;
      #1;
      checks++; if (REN_VALID !== 1'b1 || REN_DATA !== ref_mem[2]) begin errors++; $display("[TB] FAIL stream_data2: got v=%b %h expected 1 %h", REN_VALID, REN_DATA, ref_mem[2]); end
      @(negedge CLK); #1;
      checks++; if (REN_VALID !== 1'b0) begin errors++; $display("[TB] FAIL stream_valid_end: got %b expected 0", REN_VALID); end
      @(negedge CLK);
   endtask

   task automatic test_starvation();
      logic [11:0] a;
      int acks;
      a = 12'd9; acks = 0;
      AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 0; AVL_ADDR = a; AVL_BYTE_EN = 4'hF;
      REN_REQ = 1; REN_ADDR = 12'd100;
      for (int cyc = 0; cyc <= STARVE_MAX + 1; cyc++) begin
         #1;
         if (cyc < STARVE_MAX) begin
            if (REN_ACK === 1'b1) acks++;
            checks++; if (AVL_WAITREQUEST !== 1'b1) begin errors++; $display("[TB] FAIL starve_wait%0d: got %b expected 1", cyc, AVL_WAITREQUEST); end
         end else if (cyc == STARVE_MAX) begin
            checks++; if (REN_ACK !== 1'b0 || RAM_ADDR !== a || AVL_WAITREQUEST !== 1'b1) begin errors++; $display("[TB] FAIL starve_force: got ack=%b addr=%0d wait=%b expected 0 %0d 1", REN_ACK, RAM_ADDR, AVL_WAITREQUEST, a); end
         end else begin
            checks++; if (REN_ACK !== 1'b1 || AVL_WAITREQUEST !== 1'b0) begin errors++; $display("[TB] FAIL starve_resume: got ack=%b wait=%b expected 1 0", REN_ACK, AVL_WAITREQUEST); end
            checks++; if (AVL_READDATA !== ref_mem[a]) begin errors++; $display("[TB] FAIL starve_readdata: got %h expected %h", AVL_READDATA, ref_mem[a]); end
            checks++; if (REN_VALID !== 1'b0) begin errors++; $display("[TB] FAIL starve_gap_valid: got %b expected 0", REN_VALID); end
            AVL_CS = 0; AVL_READ = 0;
         end
         if (cyc >= 1 && cyc <= STARVE_MAX) begin
            checks++; if (REN_VALID !== 1'b1 || REN_DATA !== ref_mem[100+cyc-1]) begin errors++; $display("[TB] FAIL starve_ren_data%0d: got v=%b %h expected 1 %h", cyc, REN_VALID, REN_DATA, ref_mem[100+cyc-1]); end
         end
         @(negedge CLK);
         if (cyc < STARVE_MAX) REN_ADDR = 12'(100 + cyc + 1);
      end
      REN_REQ = 0;
      #1;
      checks++; if (REN_VALID !== 1'b1 || REN_DATA !== ref_mem[100+STARVE_MAX]) begin errors++; $display("[TB] FAIL starve_ren_last: got v=%b %h expected 1 %h", REN_VALID, REN_DATA, ref_mem[100+STARVE_MAX]); end
      checks++; if (acks != STARVE_MAX) begin errors++; $display("[TB] FAIL starve_ack_count: got %0d expected %0d", acks, STARVE_MAX); end
      @(negedge CLK);
   endtask

   task automatic test_reset_pending_read();
      AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 0; AVL_ADDR = 12'd5; AVL_BYTE_EN = 4'hF;
      #1;
      checks++; if (AVL_WAITREQUEST !== 1'b1) begin errors++; $display("[TB] FAIL rst_rd_grant: got %b expected 1", AVL_WAITREQUEST); end
      @(negedge CLK);
      RESET_N = 0; REN_REQ = 1; REN_ADDR = 12'd7;
      #1;
      checks++; if (AVL_WAITREQUEST !== 1'b1 || AVL_READDATA !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd_dropped: got wait=%b data=%h expected 1 0", AVL_WAITREQUEST, AVL_READDATA); end
      checks++; if (REN_VALID !== 1'b0 || REN_ACK !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_ren: got valid=%b ack=%b expected 0 0", REN_VALID, REN_ACK); end
      @(negedge CLK);
      REN_REQ = 0;
      RESET_N = 1;
      #1;
      checks++; if (AVL_WAITREQUEST !== 1'b1 || RAM_ADDR !== 12'd5) begin errors++; $display("[TB] FAIL rst_rd_regrant: got wait=%b addr=%0d expected 1 5", AVL_WAITREQUEST, RAM_ADDR); end
      @(negedge CLK); #1;
      checks++; if (AVL_WAITREQUEST !== 1'b0 || AVL_READDATA !== ref_mem[5]) begin errors++; $display("[TB] FAIL rst_rd_complete: got wait=%b data=%h expected 0 %h", AVL_WAITREQUEST, AVL_READDATA, ref_mem[5]); end
      AVL_CS = 0; AVL_READ = 0;
      @(negedge CLK);
   endtask

   // Random CPU and renderer traffic; expected data comes from the shadow memory.
   task automatic test_random(input int ncycles);
      logic        cpu_active, wr_commit, op_wr, ren_pending, prev_ack;
      logic [11:0] op_addr;
      logic [31:0] op_data, exp_w;
      logic [3:0]  op_be;
      int          op_wait;
      logic [31:0] ren_q [$];
      cpu_active = 0; wr_commit = 0; ren_pending = 0; prev_ack = 0; op_wait = 0;
      op_wr = 0; op_addr = 0; op_data = 0; op_be = 0;
      for (int c = 0; c < ncycles; c++) begin
         if (wr_commit) begin
            if (op_addr < NUM_WORDS) ref_mem[op_addr] = merge_bytes(ref_mem[op_addr], op_data, op_be);
            wr_commit = 0;
            AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
         end
         if (!cpu_active && $urandom_range(0, 99) < 40) begin
            op_wr   = 1'($urandom_range(0, 1));
            op_addr = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(NUM_WORDS, 4095))
                                                  : 12'($urandom_range(0, NUM_WORDS-1));
            op_data = $urandom;
            op_be   = 4'($urandom_range(0, 15));
            AVL_CS = 1; AVL_WRITE = op_wr;
            AVL_READ = op_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            AVL_ADDR = op_addr; AVL_WRITEDATA = op_data; AVL_BYTE_EN = op_be;
            cpu_active = 1; op_wait = 0;
         end
         if (!ren_pending) begin
            REN_REQ = 1'($urandom_range(0, 1));
            REN_ADDR = 12'($urandom_range(0, NUM_WORDS-1));
            ren_pending = REN_REQ;
         end
         #1;
         checks++; if (REN_VALID !== prev_ack) begin errors++; $display("[TB] FAIL rnd_valid c%0d: got %b expected %b", c, REN_VALID, prev_ack); end
         if (REN_VALID === 1'b1 && ren_q.size() > 0) begin
            exp_w = ren_q.pop_front();
            checks++; if (REN_DATA !== exp_w) begin errors++; $display("[TB] FAIL rnd_ren_data c%0d: got %h expected %h", c, REN_DATA, exp_w); end
         end
         prev_ack = REN_ACK;
         if (REN_ACK === 1'b1) begin
            checks++; if (RAM_ADDR !== REN_ADDR || RAM_WE !== 1'b0) begin errors++; $display("[TB] FAIL rnd_ren_port c%0d: got addr=%0d we=%b expected %0d 0", c, RAM_ADDR, RAM_WE, REN_ADDR); end
            ren_q.push_back(ref_mem[REN_ADDR]);
            ren_pending = 0;
         end
         if (cpu_active) begin
            if (AVL_WAITREQUEST === 1'b0) begin
               if (op_wr) begin
                  checks++; if (RAM_WE !== (op_addr < NUM_WORDS) || RAM_ADDR !== op_addr) begin errors++; $display("[TB] FAIL rnd_write c%0d: got we=%b addr=%0d expected %b %0d", c, RAM_WE, RAM_ADDR, (op_addr < NUM_WORDS), op_addr); end
                  wr_commit = 1;
               end else begin
                  exp_w = (op_addr < NUM_WORDS) ? ref_mem[op_addr] : 32'h0;
                  checks++; if (AVL_READDATA !== exp_w) begin errors++; $display("[TB] FAIL rnd_read c%0d addr %0d: got %h expected %h", c, op_addr, AVL_READDATA, exp_w); end
                  AVL_CS = 0; AVL_READ = 0;
               end
               checks++; if (op_wait > (op_wr ? STARVE_MAX : STARVE_MAX + 1)) begin errors++; $display("[TB] FAIL rnd_latency c%0d: got %0d wait cycles expected at most %0d", c, op_wait, op_wr ? STARVE_MAX : STARVE_MAX + 1); end
               cpu_active = 0;
            end else begin
               op_wait++;
               if (op_wait > STARVE_MAX + 4) begin
                  checks++; errors++;
                  $display("[TB] FAIL rnd_timeout c%0d: got %0d wait cycles expected at most %0d", c, op_wait, STARVE_MAX + 1);
                  AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
                  cpu_active = 0;
               end
            end
         end
         @(negedge CLK);
      end
      if (wr_commit && op_addr < NUM_WORDS) ref_mem[op_addr] = merge_bytes(ref_mem[op_addr], op_data, op_be);
      idle_inputs();
      #1;
      checks++; if (REN_VALID !== prev_ack) begin errors++; $display("[TB] FAIL rnd_valid_tail: got %b expected %b", REN_VALID, prev_ack); end
      if (REN_VALID === 1'b1 && ren_q.size() > 0) begin
         exp_w = ren_q.pop_front();
         checks++; if (REN_DATA !== exp_w) begin errors++; $display("[TB] FAIL rnd_ren_tail: got %h expected %h", REN_DATA, exp_w); end
      end
      @(negedge CLK);
   endtask

   initial begin
      for (int i = 0; i < NUM_WORDS; i++) ref_mem[i] = init_word(i);
      idle_inputs();
      test_reset();
      test_write_basic();
      test_byte_enable();
      test_unmapped();
      test_ren_stream();
      test_starvation();
      test_reset_pending_read();
      test_random(400);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
Shares one single-port, byte-enabled, synchronous-read VRAM (read latency 1 cycle) between two requesters: the Avalon-MM CPU slave and the text renderer's glyph/attribute prefetch. The renderer normally has priority because it has a hard pixel deadline. A starvation counter guarantees that a pending CPU access is eventually serviced. The block sits between the Avalon slave of the VGA text peripheral and its VRAM block.

Parameters:
ADDR_W, 12, word address width of VRAM and both requesters
DATA_W, 32, VRAM word width
NUM_WORDS, 601, implemented words (600 VRAM + 1 control); higher addresses are unmapped
STARVE_MAX, 8, consecutive denied CPU cycles before the CPU is force-granted

Ports:
CLK  in  1  system clock, 50 MHz
RESET_N  in  1  asynchronous, active-low reset
AVL_CS  in  1  Avalon chip select
AVL_READ  in  1  Avalon read
AVL_WRITE  in  1  Avalon write
AVL_BYTE_EN  in  4  Avalon byte enables
AVL_ADDR  in  ADDR_W  Avalon word address
AVL_WRITEDATA  in  DATA_W  Avalon write data
AVL_READDATA  out  DATA_W  Avalon read data, valid when the read completes
AVL_WAITREQUEST  out  1  Avalon stall
REN_REQ  in  1  renderer fetch request (level; held until acked)
REN_ADDR  in  ADDR_W  renderer word address
REN_ACK  out  1  renderer request granted this cycle
REN_DATA  out  DATA_W  fetched word
REN_VALID  out  1  REN_DATA valid (exactly 1 cycle after REN_ACK)
RAM_ADDR  out  ADDR_W  VRAM address
RAM_BE  out  4  VRAM byte enables
RAM_WDATA  out  DATA_W  VRAM write data
RAM_WE  out  1  VRAM write enable
RAM_Q  in  DATA_W  VRAM read data (registered inside the RAM, 1-cycle latency)

Behaviour:
- Request definitions:
  - cpu_req = AVL_CS & (AVL_READ | AVL_WRITE) & ~rd_pend.
  - If AVL_READ and AVL_WRITE are both asserted, the access is treated as a write.
- Grant rule, evaluated combinationally each cycle from the requests and registered state:
  - cpu_grant = cpu_req & (~REN_REQ | starve_cnt == STARVE_MAX).
  - ren_grant = REN_REQ & ~cpu_grant.
  - At most one grant per cycle.
- RAM port:
  - On cpu_grant: RAM_ADDR = AVL_ADDR. On a write, also RAM_WE = 1 when AVL_ADDR < NUM_WORDS, RAM_BE = AVL_BYTE_EN, RAM_WDATA = AVL_WRITEDATA.
  - On ren_grant: RAM_ADDR = REN_ADDR, RAM_WE = 0.
  - Otherwise: RAM_WE = 0, RAM_BE = 0, RAM_ADDR = 0.
- CPU write:
  - Completes in the grant cycle: AVL_WAITREQUEST = 0 that cycle.
  - An unmapped address (>= NUM_WORDS) is acknowledged but dropped (RAM_WE = 0).
  - Byte enable 0000: acknowledged, no bytes change.
- CPU read:
  - Grant cycle G sets registered rd_pend and rd_unmapped; AVL_WAITREQUEST stays 1 in G.
  - In G+1: rd_pend = 1, AVL_WAITREQUEST = 0, AVL_READDATA = RAM_Q, or 0 if rd_unmapped. rd_pend clears at the end of G+1.
  - The RAM port is free in G+1 and may serve the renderer.
- AVL_WAITREQUEST = 1 whenever cpu_req is asserted without a write grant and without rd_pend completion. It is 0 when idle.
- AVL_READDATA holds its last value outside completion cycles.
- Renderer:
  - REN_ACK = ren_grant, combinational.
  - REN_VALID is registered: it equals REN_ACK delayed by one cycle.
  - REN_DATA = RAM_Q, valid while REN_VALID = 1.
  - Back-to-back renderer grants are allowed; one word per cycle is sustained.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments each cycle cpu_req = 1 and cpu_grant = 0, saturating at STARVE_MAX.
  - Clears on cpu_grant, or when cpu_req = 0.
  - A forced grant denies the renderer exactly one cycle.
- Reset (RESET_N low, asynchronous):
  - rd_pend, rd_unmapped, starve_cnt, REN_VALID and AVL_READDATA clear to 0.
  - AVL_WAITREQUEST = 1 while in reset. REN_ACK = 0 and RAM_WE = 0 while in reset.
  - Reset during a pending read drops the read without completion. The master still holding the request is re-arbitrated after reset releases.

Test Plan:
- Idle, CPU write addr 5, data 0xDEADBEEF, BE 1111 -> RAM_WE = 1, RAM_ADDR = 5, WAITREQUEST = 0 same cycle; a later read of 5 completes 1 cycle after grant with READDATA 0xDEADBEEF.
- CPU write BE 0100 data 0x00AB0000 over word 0x11223344 -> readback 0x11AB3344.
- REN_REQ held continuously with a CPU read pending, STARVE_MAX = 8 -> REN_ACK high 8 cycles, CPU granted on cycle 9 (REN_ACK = 0), then the renderer resumes; read completes the next cycle.
- Renderer streaming addrs 0,1,2 back-to-back -> REN_VALID high 3 consecutive cycles, REN_DATA equals the contents of words 0,1,2 in order.
- CPU read addr 700 -> completes with READDATA = 0. CPU write addr 700 -> acknowledged, RAM_WE stays 0.
- Assert RESET_N = 0 in the cycle after a CPU read grant -> no completion, REN_VALID = 0; after release the read is re-granted and completes with correct data.
